// File: rtl/fwd_pipe_pkg.sv
// Shared layout of the packed pipeline entry used by fwd_stage and fwd_pipe.
// Bit order, LSB first: valid, wen, rdy, addr[ADDR_W], data[DATA_W].
package fwd_pipe_pkg;

  localparam int unsigned OFF_VALID = 0;
  localparam int unsigned OFF_WEN   = 1;
  localparam int unsigned OFF_RDY   = 2;
  localparam int unsigned OFF_ADDR  = 3;
  localparam int unsigned FLAG_W    = 3;

  // Total width of one packed entry.
  function automatic int unsigned entry_w(input int unsigned addr_w, input int unsigned data_w);
    return FLAG_W + addr_w + data_w;
  endfunction

  // Bit offset of the data field, which sits directly above the address.
  function automatic int unsigned off_data(input int unsigned addr_w);
    return OFF_ADDR + addr_w;
  endfunction

endpackage

// File: rtl/fwd_stage.sv
// One pipeline entry register with rst > flush > enable priority.
// When IS_LD is set, a not-ready record is completed from ld_data_i on its
// output side, so the successor stage captures the merged value.
module fwd_stage
  import fwd_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit IS_LD  = 1'b0
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    en_i,
  input  logic                                    flush_i,
  input  logic [entry_w(ADDR_W, DATA_W)-1:0]      entry_i,
  input  logic [DATA_W-1:0]                       ld_data_i,
  output logic [entry_w(ADDR_W, DATA_W)-1:0]      eff_o
);

  localparam int EW   = entry_w(ADDR_W, DATA_W);
  localparam int DOFF = off_data(ADDR_W);

  logic [EW-1:0] entry_q;
  logic [EW-1:0] entry_d;

  // Next-state selection: a flush inserts an all-zero bubble and beats enable.
  always_comb begin
    entry_d = entry_q;
    if (flush_i) begin
      entry_d = '0;
    end else if (en_i) begin
      entry_d = entry_i;
    end
  end

  // Entry register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  generate
    if (IS_LD) begin : g_ld
      // Late-data merge: a load picks up ld_data_i here and is ready from now on.
      always_comb begin
        eff_o = entry_q;
        if (!entry_q[OFF_RDY]) begin
          eff_o[DOFF +: DATA_W] = ld_data_i;
        end
        eff_o[OFF_RDY] = 1'b1;
      end
    end else begin : g_plain
      logic unused_ld;
      assign unused_ld = ^ld_data_i;
      assign eff_o     = entry_q;
    end
  endgenerate

endmodule

// File: rtl/fwd_pipe.sv
// Writeback-tracking pipeline with operand forwarding and load-use stall
// detection. Stage 0 is the youngest record, stage DEPTH-1 drives the
// register-file write port. Read ports take the youngest live matching record.
module fwd_pipe
  import fwd_pipe_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 3,
  parameter int NRD      = 2,
  parameter int LD_STAGE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    in_wen,
  input  logic [ADDR_W-1:0]       in_addr,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_rdy,
  input  logic [DEPTH-1:0]        stage_en,
  input  logic [DEPTH-1:0]        stage_flush,
  input  logic [DATA_W-1:0]       ld_data,
  input  logic [NRD*ADDR_W-1:0]   rd_addr,
  input  logic [NRD*DATA_W-1:0]   rd_reg_data,
  output logic [NRD*DATA_W-1:0]   rd_data,
  output logic [NRD-1:0]          rd_stall,
  output logic                    stall_any,
  output logic                    wb_wen,
  output logic [ADDR_W-1:0]       wb_addr,
  output logic [DATA_W-1:0]       wb_data
);

  localparam int EW   = entry_w(ADDR_W, DATA_W);
  localparam int DOFF = off_data(ADDR_W);

  logic [EW-1:0]          in_entry;
  logic [EW-1:0]          stage_eff [DEPTH];
  logic [DEPTH-1:0]       live;
  logic [NRD*DEPTH-1:0]   hit;

  assign in_entry = {in_data, in_addr, in_rdy, in_wen, in_valid};

  genvar gi, gp;

  // Stage chain: stage 0 loads the new record, stage k loads stage k-1's
  // effective (possibly late-data-merged) value.
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [EW-1:0] prev_entry;
      if (gi == 0) begin : g_first
        assign prev_entry = in_entry;
      end else begin : g_next
        assign prev_entry = stage_eff[gi-1];
      end

      fwd_stage #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .IS_LD  (gi == LD_STAGE)
      ) u_stage (
        .clk       (clk),
        .rst       (rst),
        .en_i      (stage_en[gi]),
        .flush_i   (stage_flush[gi]),
        .entry_i   (prev_entry),
        .ld_data_i (ld_data),
        .eff_o     (stage_eff[gi])
      );

      // Writes to r0 never forward, so they are not live.
      assign live[gi] = stage_eff[gi][OFF_VALID] & stage_eff[gi][OFF_WEN] &
                        (stage_eff[gi][OFF_ADDR +: ADDR_W] != '0);
    end
  endgenerate

  // Per-port priority search: match every stage, then let the youngest win.
  generate
    for (gp = 0; gp < NRD; gp++) begin : g_port
      logic [ADDR_W-1:0] port_addr;
      logic [DATA_W-1:0] port_reg;
      logic [DATA_W-1:0] fwd_data;
      logic              fwd_stall;

      assign port_addr = rd_addr[gp*ADDR_W +: ADDR_W];
      assign port_reg  = rd_reg_data[gp*DATA_W +: DATA_W];

      for (gi = 0; gi < DEPTH; gi++) begin : g_match
        assign hit[gp*DEPTH + gi] = live[gi] &
                                    (stage_eff[gi][OFF_ADDR +: ADDR_W] == port_addr);
      end

      // Walk oldest to youngest so the lowest-index hit overrides the rest.
      always_comb begin
        fwd_data  = port_reg;
        fwd_stall = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
          if (hit[gp*DEPTH + k]) begin
            if (stage_eff[k][OFF_RDY]) begin
              fwd_data  = stage_eff[k][DOFF +: DATA_W];
              fwd_stall = 1'b0;
            end else begin
              fwd_data  = port_reg;
              fwd_stall = 1'b1;
            end
          end
        end
      end

      assign rd_data[gp*DATA_W +: DATA_W] = fwd_data;
      assign rd_stall[gp]                 = fwd_stall;
    end
  endgenerate

  assign stall_any = |rd_stall;

  // Register-file write port; r0 writes are passed through and ignored there.
  assign wb_wen  = stage_eff[DEPTH-1][OFF_VALID] & stage_eff[DEPTH-1][OFF_WEN];
  assign wb_addr = stage_eff[DEPTH-1][OFF_ADDR +: ADDR_W];
  assign wb_data = stage_eff[DEPTH-1][DOFF +: DATA_W];

endmodule

// File: tb/tb_fwd_pipe.sv
// Directed bench for fwd_pipe with default parameters (DEPTH=3, LD_STAGE=1, NRD=2).
module tb_fwd_pipe;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 3;
  localparam int NRD    = 2;

  localparam logic [DATA_W-1:0] REG0 = 32'h0000_5555;
  localparam logic [DATA_W-1:0] REG1 = 32'h0000_6666;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic                  in_wen;
  logic [ADDR_W-1:0]     in_addr;
  logic [DATA_W-1:0]     in_data;
  logic                  in_rdy;
  logic [DEPTH-1:0]      stage_en;
  logic [DEPTH-1:0]      stage_flush;
  logic [DATA_W-1:0]     ld_data;
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_reg_data;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_stall;
  logic                  stall_any;
  logic                  wb_wen;
  logic [ADDR_W-1:0]     wb_addr;
  logic [DATA_W-1:0]     wb_data;

  int checks = 0;
  int errors = 0;

  fwd_pipe #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .NRD      (NRD),
    .LD_STAGE (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_wen      (in_wen),
    .in_addr     (in_addr),
    .in_data     (in_data),
    .in_rdy      (in_rdy),
    .stage_en    (stage_en),
    .stage_flush (stage_flush),
    .ld_data     (ld_data),
    .rd_addr     (rd_addr),
    .rd_reg_data (rd_reg_data),
    .rd_data     (rd_data),
    .rd_stall    (rd_stall),
    .stall_any   (stall_any),
    .wb_wen      (wb_wen),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic insert(input logic wen, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] data, input logic rdy);
    in_valid = 1'b1;
    in_wen   = wen;
    in_addr  = addr;
    in_data  = data;
    in_rdy   = rdy;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_wen   = 1'b0;
    in_addr  = '0;
    in_data  = '0;
    in_rdy   = 1'b0;
  endtask

  task automatic set_rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  initial begin
    rst         = 1'b1;
    idle();
    stage_en    = 3'b111;
    stage_flush = 3'b000;
    ld_data     = '0;
    rd_reg_data = {REG1, REG0};
    set_rd(5'd8, 5'd9);
    step();
    step();

    // Reset state
    chk("rst_wb_wen",   64'(wb_wen), 64'd0);
    chk("rst_wb_addr",  64'(wb_addr), 64'd0);
    chk("rst_wb_data",  64'(wb_data), 64'd0);
    chk("rst_stall",    64'(rd_stall), 64'd0);
    chk("rst_stall_any",64'(stall_any), 64'd0);
    chk("rst_rd_data",  64'(rd_data), {REG1, REG0});
    rst = 1'b0;

    // Single ALU write to r8 travels to WB in three cycles
    insert(1'b1, 5'd8, 32'h11, 1'b1);
    step();
    idle();
    chk("r8_s0_rd",   64'(rd_data[31:0]), 64'h11);
    chk("r8_s0_wb",   64'(wb_wen), 64'd0);
    step();
    chk("r8_s1_rd",   64'(rd_data[31:0]), 64'h11);
    chk("r8_s1_wb",   64'(wb_wen), 64'd0);
    step();
    chk("r8_wb_wen",  64'(wb_wen), 64'd1);
    chk("r8_wb_addr", 64'(wb_addr), 64'd8);
    chk("r8_wb_data", 64'(wb_data), 64'h11);
    chk("r8_s2_rd",   64'(rd_data[31:0]), 64'h11);
    chk("r8_s2_p1",   64'(rd_data[63:32]), 64'(REG1));
    step();
    chk("r8_gone_wb", 64'(wb_wen), 64'd0);
    chk("r8_gone_rd", 64'(rd_data[31:0]), 64'(REG0));

    // Back-to-back writes to r9: youngest wins, then older alone in WB
    set_rd(5'd9, 5'd8);
    insert(1'b1, 5'd9, 32'hA, 1'b1);
    step();
    insert(1'b1, 5'd9, 32'hB, 1'b1);
    step();
    idle();
    chk("r9_both_rd", 64'(rd_data[31:0]), 64'hB);
    stage_flush = 3'b010;
    step();
    stage_flush = 3'b000;
    chk("r9_old_rd",   64'(rd_data[31:0]), 64'hA);
    chk("r9_old_wen",  64'(wb_wen), 64'd1);
    chk("r9_old_data", 64'(wb_data), 64'hA);
    step();
    chk("r9_end_wen", 64'(wb_wen), 64'd0);
    chk("r9_end_rd",  64'(rd_data[31:0]), 64'(REG0));

    // Load-use: stall in stage 0, late data merged in stage 1
    set_rd(5'd4, 5'd9);
    insert(1'b1, 5'd4, 32'h999, 1'b0);
    step();
    idle();
    ld_data = 32'hDEAD;
    chk("ld_s0_stall",   64'(rd_stall), 64'b01);
    chk("ld_s0_any",     64'(stall_any), 64'd1);
    chk("ld_s0_rd",      64'(rd_data[31:0]), 64'(REG0));
    step();
    chk("ld_s1_stall",   64'(rd_stall), 64'b00);
    chk("ld_s1_any",     64'(stall_any), 64'd0);
    chk("ld_s1_rd",      64'(rd_data[31:0]), 64'hDEAD);
    step();
    ld_data = 32'hBEEF;
    chk("ld_wb_wen",     64'(wb_wen), 64'd1);
    chk("ld_wb_addr",    64'(wb_addr), 64'd4);
    chk("ld_wb_data",    64'(wb_data), 64'hDEAD);
    chk("ld_wb_rd",      64'(rd_data[31:0]), 64'hDEAD);
    step();

    // Writes to r0 never forward but still reach the write port
    set_rd(5'd0, 5'd0);
    insert(1'b1, 5'd0, 32'h77, 1'b1);
    step();
    idle();
    chk("r0_rd",     64'(rd_data), {REG1, REG0});
    chk("r0_stall",  64'(rd_stall), 64'd0);
    step();
    step();
    chk("r0_wb_wen", 64'(wb_wen), 64'd1);
    chk("r0_wb_addr",64'(wb_addr), 64'd0);
    chk("r0_wb_rd",  64'(rd_data[31:0]), 64'(REG0));
    step();

    // Front-end hold with stage 0 flushed: bubbles follow r5 down the pipe
    set_rd(5'd5, 5'd6);
    insert(1'b1, 5'd5, 32'h51, 1'b1);
    step();
    insert(1'b1, 5'd6, 32'h61, 1'b1);
    stage_en    = 3'b110;
    stage_flush = 3'b001;
    step();
    chk("hold1_wen",  64'(wb_wen), 64'd0);
    chk("hold1_r5",   64'(rd_data[31:0]), 64'h51);
    chk("hold1_r6",   64'(rd_data[63:32]), 64'(REG1));
    step();
    chk("hold2_wen",  64'(wb_wen), 64'd1);
    chk("hold2_addr", 64'(wb_addr), 64'd5);
    stage_en    = 3'b111;
    stage_flush = 3'b000;
    idle();
    step();
    chk("bubble1_wen", 64'(wb_wen), 64'd0);
    step();
    chk("bubble2_wen", 64'(wb_wen), 64'd0);
    chk("bubble2_r6",  64'(rd_data[63:32]), 64'(REG1));

    // Flush and enable both high on stage 2: flush wins
    set_rd(5'd7, 5'd5);
    insert(1'b1, 5'd7, 32'h71, 1'b1);
    step();
    idle();
    step();
    chk("r7_s1_rd", 64'(rd_data[31:0]), 64'h71);
    stage_flush = 3'b100;
    step();
    stage_flush = 3'b000;
    chk("fl2_wen", 64'(wb_wen), 64'd0);
    chk("fl2_rd",  64'(rd_data[31:0]), 64'(REG0));

    // Reset with three records in flight
    set_rd(5'd1, 5'd3);
    insert(1'b1, 5'd1, 32'h101, 1'b1);
    step();
    insert(1'b1, 5'd2, 32'h202, 1'b1);
    step();
    insert(1'b1, 5'd3, 32'h303, 1'b0);
    step();
    idle();
    chk("pre_rst_wen",   64'(wb_wen), 64'd1);
    chk("pre_rst_addr",  64'(wb_addr), 64'd1);
    chk("pre_rst_rd",    64'(rd_data[31:0]), 64'h101);
    chk("pre_rst_stall", 64'(rd_stall), 64'b10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_wen",   64'(wb_wen), 64'd0);
    chk("mrst_addr",  64'(wb_addr), 64'd0);
    chk("mrst_data",  64'(wb_data), 64'd0);
    chk("mrst_stall", 64'(rd_stall), 64'd0);
    chk("mrst_any",   64'(stall_any), 64'd0);
    chk("mrst_rd",    64'(rd_data), {REG1, REG0});
    step();
    chk("mrst_wen1",  64'(wb_wen), 64'd0);
    step();
    chk("mrst_wen2",  64'(wb_wen), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
